// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, runtime prescale oversampling,
// 3-sample majority vote per bit, optional parity, registered result pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  party_en,
    input  logic                  party_typ,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q;
    logic                    rx_meta_q;
    logic                    rx_s_q;
    logic [PRESCALE_W-1:0]   edge_cnt_q;
    logic [BCW-1:0]          bit_cnt_q;
    logic [PRESCALE_W-1:0]   presc_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic [2:0]              smp_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_bad_q;
    logic [DATA_WIDTH-1:0]   p_data_q;
    logic                    data_valid_q;
    logic                    par_err_q;
    logic                    stp_err_q;

    logic [PRESCALE_W-1:0]   half;
    logic                    bit_end;
    logic                    voted;

    assign half    = presc_q >> 1;
    // ">=" keeps the counter bounded even for out-of-range prescale values
    assign bit_end = (edge_cnt_q >= (presc_q - PRESCALE_W'(1)));
    assign voted   = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            smp_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            rx_meta_q    <= RX_IN;
            rx_s_q       <= rx_meta_q;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            if (state_q != IDLE) begin
                if (edge_cnt_q == half - PRESCALE_W'(1)) smp_q[0] <= rx_s_q;
                if (edge_cnt_q == half)                  smp_q[1] <= rx_s_q;
                if (edge_cnt_q == half + PRESCALE_W'(1)) smp_q[2] <= rx_s_q;
                edge_cnt_q <= bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
            end

            case (state_q)
                IDLE: begin
                    // the detection cycle is edge 0, so the count resumes at 1
                    if (!rx_s_q) begin
                        state_q    <= START;
                        edge_cnt_q <= PRESCALE_W'(1);
                        presc_q    <= prescale;
                        par_en_q   <= party_en;
                        par_typ_q  <= party_typ;
                        par_bad_q  <= 1'b0;
                    end else begin
                        edge_cnt_q <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        state_q   <= voted ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= {voted, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_bad_q <= (voted != ((^shift_q) ^ par_typ_q));
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        stp_err_q <= ~voted;
                        par_err_q <= par_bad_q;
                        if (voted && !par_bad_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = (state_q != IDLE);

endmodule
